i2c_master_fsm: RTL and testbench

- Bit-level control FSM of the I2C master; sits directly upstream of the I2C data path and drives its control strobes (sda_low_en, write_addr_en, write_data_en, receive_data_en) and its bit index.
- Sequences START, 8-bit address, slave ACK, write/read data bytes with ACK/NACK, and STOP.
- Handshakes with the TX FIFO (pop after each acknowledged write byte) and the RX FIFO (push after each received byte).
- One FSM state equals one bit period, which is one i2c_core_clk_i cycle.

---
 rtl/i2c_master_fsm.sv | 239 +++++++++++++++++++++++
 tb/tb_i2c_master_fsm.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_fsm.sv
// I2C master bit-level control FSM.
// One state equals one bit period (one i2c_core_clk_i cycle). Sequences START,
// 8 address bits, the slave ACK, write/read data bytes with their ACK/NACK bit,
// and STOP. Drives the data-path strobes and the MSB-first bit index.
//
// Ports:
//   i2c_core_clk_i     core clock, one bit period per cycle
//   reset_i            asynchronous active-high reset
//   enable_i           rising edge in IDLE starts a transaction; level keeps bytes going
//   rw_i               0 = write, 1 = read (taken in START)
//   i2c_sda_i          SDA line, looked at in the ACK states
//   tx_fifo_empty_i    TX FIFO empty (first-word-fall-through)
//   rx_fifo_full_i     RX FIFO full
//   count_bit_o        bit index into the current byte
//   sda_low_en_o       force SDA low (START, STOP, master ACK)
//   write_addr_en_o    drive address bit
//   write_data_en_o    drive data bit
//   receive_data_en_o  capture SDA into the data path
//   sda_oe_o           master drives SDA; 0 releases it
//   scl_en_o           SCL toggles this bit period; 0 holds SCL high
//   tx_rd_en_o         one-cycle TX FIFO pop
//   rx_wr_en_o         one-cycle RX FIFO push
//   busy_o             transaction in progress
//   done_o             one-cycle pulse as STOP returns to IDLE
//   ack_err_o          sticky slave NACK flag, cleared by the next START
//   rx_ovf_o           sticky dropped-byte flag, cleared by the next START
module i2c_master_fsm #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned CNT_SIZE  = 3
) (
  input  logic                i2c_core_clk_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic                rw_i,
  input  logic                i2c_sda_i,
  input  logic                tx_fifo_empty_i,
  input  logic                rx_fifo_full_i,
  output logic [CNT_SIZE-1:0] count_bit_o,
  output logic                sda_low_en_o,
  output logic                write_addr_en_o,
  output logic                write_data_en_o,
  output logic                receive_data_en_o,
  output logic                sda_oe_o,
  output logic                scl_en_o,
  output logic                tx_rd_en_o,
  output logic                rx_wr_en_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                ack_err_o,
  output logic                rx_ovf_o
);

  localparam logic [CNT_SIZE-1:0] CNT_LAST = CNT_SIZE'(DATA_SIZE - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE_DATA,
    ST_WRITE_ACK,
    ST_WAIT_TX,
    ST_READ_DATA,
    ST_READ_ACK,
    ST_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_SIZE-1:0] count_q, count_d;
  logic                enable_q;
  logic                rw_q, rw_d;
  logic                more_q, more_d;
  logic                ack_err_q, ack_err_d;
  logic                rx_ovf_q, rx_ovf_d;
  logic                done_q, done_d;

  // State and bookkeeping registers. enable_q resets high so that an enable
  // level still held across a reset is not mistaken for a new rising edge.
  always_ff @(posedge i2c_core_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      count_q   <= CNT_LAST;
      enable_q  <= 1'b1;
      rw_q      <= 1'b0;
      more_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rx_ovf_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      enable_q  <= enable_i;
      rw_q      <= rw_d;
      more_q    <= more_d;
      ack_err_q <= ack_err_d;
      rx_ovf_q  <= rx_ovf_d;
      done_q    <= done_d;
    end
  end

  // Next-state, bit counter and sticky flag logic.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rw_d      = rw_q;
    more_d    = more_q;
    ack_err_d = ack_err_q;
    rx_ovf_d  = rx_ovf_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable_i && !enable_q) state_d = ST_START;
      end
      ST_START: begin
        rw_d      = rw_i;
        ack_err_d = 1'b0;
        rx_ovf_d  = 1'b0;
        count_d   = CNT_LAST;
        state_d   = ST_ADDR;
      end
      ST_ADDR, ST_WRITE_DATA, ST_READ_DATA: begin
        if (count_q == '0) begin
          count_d = CNT_LAST;
          if (state_q == ST_ADDR)            state_d = ST_ADDR_ACK;
          else if (state_q == ST_WRITE_DATA) state_d = ST_WRITE_ACK;
          else                               state_d = ST_READ_ACK;
        end else begin
          count_d = count_q - CNT_SIZE'(1);
        end
      end
      ST_ADDR_ACK: begin
        if (i2c_sda_i) begin
          ack_err_d = 1'b1;
          state_d   = ST_STOP;
        end else if (rw_q) begin
          state_d = ST_READ_DATA;
        end else if (!tx_fifo_empty_i) begin
          state_d = ST_WRITE_DATA;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_WRITE_ACK: begin
        if (i2c_sda_i) begin
          ack_err_d = 1'b1;
          state_d   = ST_STOP;
        end else begin
          // Remember enable now; the FIFO flag is only meaningful after the pop.
          more_d  = enable_i;
          state_d = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (more_q && !tx_fifo_empty_i) state_d = ST_WRITE_DATA;
        else                            state_d = ST_STOP;
      end
      ST_READ_ACK: begin
        if (rx_fifo_full_i) rx_ovf_d = 1'b1;
        if (enable_i && !rx_fifo_full_i) state_d = ST_READ_DATA;
        else                             state_d = ST_STOP;
      end
      ST_STOP: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic sda_low_en_c, write_addr_en_c, write_data_en_c, receive_data_en_c;
  logic sda_oe_c, scl_en_c, tx_rd_en_c, rx_wr_en_c;

  // Output decode from the registered state; the ACK states also fold in the
  // line/FIFO condition seen during that bit period.
  always_comb begin
    sda_low_en_c      = 1'b0;
    write_addr_en_c   = 1'b0;
    write_data_en_c   = 1'b0;
    receive_data_en_c = 1'b0;
    sda_oe_c          = 1'b0;
    scl_en_c          = 1'b0;
    tx_rd_en_c        = 1'b0;
    rx_wr_en_c        = 1'b0;

    unique case (state_q)
      ST_START, ST_STOP: begin
        sda_low_en_c = 1'b1;
        sda_oe_c     = 1'b1;
      end
      ST_ADDR: begin
        write_addr_en_c = 1'b1;
        sda_oe_c        = 1'b1;
        scl_en_c        = 1'b1;
      end
      ST_ADDR_ACK: begin
        scl_en_c = 1'b1;
      end
      ST_WRITE_DATA: begin
        write_data_en_c = 1'b1;
        sda_oe_c        = 1'b1;
        scl_en_c        = 1'b1;
      end
      ST_WRITE_ACK: begin
        scl_en_c   = 1'b1;
        tx_rd_en_c = !i2c_sda_i;
      end
      ST_READ_DATA: begin
        receive_data_en_c = 1'b1;
        scl_en_c          = 1'b1;
      end
      ST_READ_ACK: begin
        scl_en_c   = 1'b1;
        rx_wr_en_c = !rx_fifo_full_i;
        // Master ACK only when another byte is wanted and can be stored.
        if (enable_i && !rx_fifo_full_i) begin
          sda_low_en_c = 1'b1;
          sda_oe_c     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign count_bit_o       = count_q;
  assign sda_low_en_o      = sda_low_en_c;
  assign write_addr_en_o   = write_addr_en_c;
  assign write_data_en_o   = write_data_en_c;
  assign receive_data_en_o = receive_data_en_c;
  assign sda_oe_o          = sda_oe_c;
  assign scl_en_o          = scl_en_c;
  assign tx_rd_en_o        = tx_rd_en_c;
  assign rx_wr_en_o        = rx_wr_en_c;
  assign busy_o            = (state_q != ST_IDLE);
  assign done_o            = done_q;
  assign ack_err_o         = ack_err_q;
  assign rx_ovf_o          = rx_ovf_q;

endmodule

// File: tb/tb_i2c_master_fsm.sv
// Bench for i2c_master_fsm: planned transactions drive a slave/FIFO model,
// expected FIFO pops, pushes and done pulses are queued with their bit-period
// offsets, and a monitor matches them against what the DUT presents.
module tb_i2c_master_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_i, rw_i, i2c_sda_i, tx_fifo_empty_i, rx_fifo_full_i;
  logic [2:0] count_bit_o;
  logic       sda_low_en_o, write_addr_en_o, write_data_en_o, receive_data_en_o;
  logic       sda_oe_o, scl_en_o, tx_rd_en_o, rx_wr_en_o;
  logic       busy_o, done_o, ack_err_o, rx_ovf_o;

  always #5 clk = ~clk;

  i2c_master_fsm #(.DATA_SIZE(8), .CNT_SIZE(3)) dut (
    .i2c_core_clk_i    (clk),
    .reset_i           (rst),
    .enable_i          (enable_i),
    .rw_i              (rw_i),
    .i2c_sda_i         (i2c_sda_i),
    .tx_fifo_empty_i   (tx_fifo_empty_i),
    .rx_fifo_full_i    (rx_fifo_full_i),
    .count_bit_o       (count_bit_o),
    .sda_low_en_o      (sda_low_en_o),
    .write_addr_en_o   (write_addr_en_o),
    .write_data_en_o   (write_data_en_o),
    .receive_data_en_o (receive_data_en_o),
    .sda_oe_o          (sda_oe_o),
    .scl_en_o          (scl_en_o),
    .tx_rd_en_o        (tx_rd_en_o),
    .rx_wr_en_o        (rx_wr_en_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .ack_err_o         (ack_err_o),
    .rx_ovf_o          (rx_ovf_o)
  );

  // kind: 0 = TX pop, 1 = RX push, 2 = done. off: bit periods after START.
  typedef struct { int kind; int off; logic a; logic b; } ev_t;
  typedef struct {
    int rw; int addr_nack; int n_fifo; int nack_byte; int n_read; int full_byte;
  } plan_t;

  ev_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  int  tx_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int off, input logic a, input logic b);
    ev_t e;
    e.kind = kind; e.off = off; e.a = a; e.b = b;
    sb_q.push_back(e);
  endtask

  // Reference: every bit is one period; START=0, address 1..8, ACK 9.
  // Write byte k occupies 10+10k..17+10k, its ACK 18+10k, a wait 19+10k.
  // Read byte k occupies 10+9k..17+9k, its ACK 18+9k. STOP then done next.
  task automatic build_expect(input plan_t p, output int done_off);
    int  ovf;
    bit  full, cont;
    done_off = 11;
    if (p.addr_nack != 0) begin
      push_ev(2, 11, 1'b1, 1'b0);
    end else if (p.rw == 0) begin
      if (p.n_fifo == 0) push_ev(2, 11, 1'b0, 1'b0);
      for (int k = 0; k < p.n_fifo; k++) begin
        if (k == p.nack_byte) begin
          done_off = 20 + 10 * k;
          push_ev(2, done_off, 1'b1, 1'b0);
          break;
        end
        push_ev(0, 18 + 10 * k, 1'b0, 1'b0);
        if (k == p.n_fifo - 1) begin
          done_off = 21 + 10 * k;
          push_ev(2, done_off, 1'b0, 1'b0);
        end
      end
    end else begin
      ovf = 0;
      for (int k = 0; k < p.n_read; k++) begin
        full = (k == p.full_byte);
        cont = (k < p.n_read - 1) && !full;
        if (full) ovf = 1;
        else      push_ev(1, 18 + 9 * k, cont, cont);
        if (!cont) begin
          done_off = 20 + 9 * k;
          push_ev(2, done_off, 1'b0, 1'(ovf));
          break;
        end
      end
    end
  endtask

  // Slave behaviour on SDA: NACK where planned, ACK otherwise, random data bits.
  function automatic logic slave_sda(input plan_t p, input int t);
    if (t == 9) return (p.addr_nack != 0);
    if (p.rw == 0)
      for (int k = 0; k < 4; k++)
        if (t == 18 + 10 * k) return (k == p.nack_byte);
    return 1'($urandom);
  endfunction

  // Monitor: match every presented pop/push/done against the scoreboard.
  task automatic sb_match(input int kind, input logic a, input logic b);
    ev_t e;
    int  off;
    off = cyc - start_cyc;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d at offset %0d, expected none", kind, off);
    end else begin
      e = sb_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_offset", off, e.off);
      check("event_flag_a", a, e.a);
      check("event_flag_b", b, e.b);
    end
  endtask

  initial begin
    int s;
    forever begin
      @(negedge clk);
      #1;
      s = int'(sda_low_en_o) + int'(write_addr_en_o) + int'(write_data_en_o) + int'(receive_data_en_o);
      check("strobe_exclusive", (s <= 1) ? 1 : 0, 1);
      if (tx_rd_en_o) sb_match(0, sda_low_en_o, sda_oe_o);
      if (rx_wr_en_o) sb_match(1, sda_low_en_o, sda_oe_o);
      if (done_o)     sb_match(2, ack_err_o, rx_ovf_o);
    end
  end

  function automatic logic [11:0] all_flags();
    return {sda_low_en_o, write_addr_en_o, write_data_en_o, receive_data_en_o,
            sda_oe_o, scl_en_o, tx_rd_en_o, rx_wr_en_o, busy_o, done_o, ack_err_o, rx_ovf_o};
  endfunction

  task automatic run_txn(input plan_t p, input int abort_at, input bit hold_high);
    int   done_off, drop_t;
    logic pop_pending;
    bit   aborted;
    enable_i = 1'b0;
    repeat (2) @(negedge clk);
    tx_cnt          = (p.rw == 0) ? p.n_fifo : 0;
    tx_fifo_empty_i = (tx_cnt <= 0);
    rx_fifo_full_i  = 1'b0;
    rw_i            = 1'(p.rw);
    i2c_sda_i       = 1'b1;
    build_expect(p, done_off);
    drop_t = (p.rw != 0) ? 12 + 9 * (p.n_read - 1) : 1 << 20;
    @(negedge clk);
    enable_i    = 1'b1;
    start_cyc   = cyc + 1;
    pop_pending = 1'b0;
    aborted     = 1'b0;
    for (int t = 0; t <= done_off + 2; t++) begin
      @(negedge clk);
      if (pop_pending) tx_cnt--;
      tx_fifo_empty_i = (tx_cnt <= 0);
      enable_i        = (t < drop_t);
      if (t > 0) rw_i = 1'($urandom);
      i2c_sda_i       = slave_sda(p, t);
      rx_fifo_full_i  = (p.rw != 0) && (p.full_byte >= 0) && (t == 18 + 9 * p.full_byte);
      #1;
      pop_pending = tx_rd_en_o;
      if (t == 1) begin
        check("ack_err_cleared_at_start", ack_err_o, 0);
        check("rx_ovf_cleared_at_start", rx_ovf_o, 0);
      end
      if (rx_fifo_full_i && p.addr_nack == 0)
        check("rx_full_nack_sda_oe", sda_oe_o, 0);
      if (t == abort_at) begin
        check("abort_count_before", count_bit_o, 4);
        check("abort_write_data_en", write_data_en_o, 1);
        rst = 1'b1;
        #1;
        check("abort_outputs_zero", all_flags(), 0);
        check("abort_count_reload", count_bit_o, 7);
        sb_q.delete();
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      check("no_restart_after_reset", busy_o, 0);
      check("count_idle_after_reset", count_bit_o, 7);
    end else if (hold_high && enable_i) begin
      repeat (4) @(negedge clk);
      #1;
      check("no_restart_on_held_enable", busy_o, 0);
    end
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  function automatic plan_t mk(input int rw, input int an, input int nf, input int nb,
                               input int nr, input int fb);
    plan_t p;
    p.rw = rw; p.addr_nack = an; p.n_fifo = nf; p.nack_byte = nb; p.n_read = nr; p.full_byte = fb;
    return p;
  endfunction

  initial begin
    plan_t p;
    rst = 1'b0;
    enable_i = 1'b0; rw_i = 1'b0; i2c_sda_i = 1'b1;
    tx_fifo_empty_i = 1'b1; rx_fifo_full_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_outputs_zero", all_flags(), 0);
    check("reset_count", count_bit_o, 7);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_txn(mk(0, 0, 2, -1, 1, -1), -1, 1'b1);   // two-byte write
    run_txn(mk(0, 1, 2, -1, 1, -1), -1, 1'b0);   // address NACK
    run_txn(mk(1, 0, 0, -1, 3, -1), -1, 1'b0);   // three-byte read
    run_txn(mk(1, 0, 0, -1, 2,  0), -1, 1'b0);   // RX full on first ACK
    run_txn(mk(0, 0, 3,  1, 1, -1), -1, 1'b0);   // data NACK on 2nd byte
    run_txn(mk(0, 0, 0, -1, 1, -1), -1, 1'b0);   // write with empty FIFO
    run_txn(mk(0, 0, 3, -1, 1, -1), 13, 1'b0);   // reset at bit index 4

    for (int i = 0; i < 40; i++) begin
      p.rw        = int'($urandom_range(0, 1));
      p.addr_nack = ($urandom_range(0, 5) == 0) ? 1 : 0;
      p.n_fifo    = int'($urandom_range(0, 3));
      p.nack_byte = (p.n_fifo > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, p.n_fifo - 1)) : -1;
      p.n_read    = int'($urandom_range(1, 3));
      p.full_byte = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, p.n_read - 1)) : -1;
      run_txn(p, -1, 1'($urandom));
    end

    enable_i = 1'b0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
